// File: rtl/cache_controller_pkg.sv
// Shared definitions for the data-cache controller and its SRAM-side peers:
// FSM state encoding, data-memory base address and the line merge helper.
package cache_controller_pkg;

  localparam logic [31:0] CC_BASE_ADDR = 32'd1024;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_READ_MISS = 3'd1;
  localparam logic [2:0] ST_FILL      = 3'd2;
  localparam logic [2:0] ST_WR_PEEK   = 3'd3;
  localparam logic [2:0] ST_WR_SRAM   = 3'd4;
  localparam logic [2:0] ST_WR_UPD    = 3'd5;

  // Place the store word in the slot picked by address bit 2, sibling in the other.
  function automatic logic [63:0] merge_line(input logic        hi_slot,
                                             input logic [31:0] store_word,
                                             input logic [31:0] sibling_word);
    if (hi_slot) begin
      merge_line = {store_word, sibling_word};
    end else begin
      merge_line = {sibling_word, store_word};
    end
  endfunction

endpackage

// File: rtl/cache_controller.sv
// Two-word-line data cache controller: zero-wait read hits, SRAM line fill on
// read miss, write-through with optional line update on write hit.
module cache_controller
  import cache_controller_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = CC_BASE_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] w_data,
  output logic        ready,
  output logic [31:0] r_data,
  output logic [18:0] cache_address,
  input  logic        cache_hit,
  input  logic [31:0] cache_out_data,
  output logic        cache_en_write,
  output logic        cache_update_data,
  output logic [31:0] cache_in_data1,
  output logic [31:0] cache_in_data2,
  output logic        sram_r_en,
  output logic        sram_w_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_w_data,
  input  logic        sram_ready,
  input  logic [63:0] sram_r_data
);

  logic [2:0]  state_r;
  logic [2:0]  state_nxt_s;
  logic [63:0] line_r;
  logic [31:0] sibling_r;
  logic        write_hit_r;
  logic        cache_en_write_r;
  logic        cache_update_data_r;
  logic [18:0] offset_s;

  // Next-state selection; a simultaneous read and write request is a write.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (mem_w_en) begin
          state_nxt_s = ST_WR_PEEK;
        end else if (mem_r_en && !cache_hit) begin
          state_nxt_s = ST_READ_MISS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_READ_MISS: begin
        if (sram_ready) begin
          state_nxt_s = ST_FILL;
        end else begin
          state_nxt_s = ST_READ_MISS;
        end
      end
      ST_FILL:    state_nxt_s = ST_IDLE;
      ST_WR_PEEK: state_nxt_s = ST_WR_SRAM;
      ST_WR_SRAM: begin
        if (sram_ready) begin
          state_nxt_s = ST_WR_UPD;
        end else begin
          state_nxt_s = ST_WR_SRAM;
        end
      end
      ST_WR_UPD:  state_nxt_s = ST_IDLE;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // State, line/sibling capture and the registered cache write strobes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r             <= ST_IDLE;
      line_r              <= 64'd0;
      sibling_r           <= 32'd0;
      write_hit_r         <= 1'b0;
      cache_en_write_r    <= 1'b0;
      cache_update_data_r <= 1'b0;
    end else begin
      state_r             <= state_nxt_s;
      cache_en_write_r    <= 1'b0;
      cache_update_data_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (mem_w_en) begin
            write_hit_r <= cache_hit;
          end
        end
        ST_READ_MISS: begin
          if (sram_ready) begin
            line_r           <= sram_r_data;
            cache_en_write_r <= 1'b1;
          end
        end
        ST_WR_PEEK: sibling_r <= cache_out_data;
        ST_WR_SRAM: begin
          if (sram_ready) begin
            line_r              <= merge_line(address[2], w_data, sibling_r);
            cache_en_write_r    <= write_hit_r;
            cache_update_data_r <= 1'b1;
          end
        end
        default: begin
          line_r <= line_r;
        end
      endcase
    end
  end

  // Peek reads the other word of the same line by flipping the word-select bit.
  always_comb begin
    offset_s = address[18:0] - BASE_ADDR[18:0];
    if (state_r == ST_WR_PEEK) begin
      cache_address = offset_s ^ 19'h00004;
    end else begin
      cache_address = offset_s;
    end
  end

  // Requester handshake: reset and idle both report ready with zero data.
  always_comb begin
    ready  = 1'b1;
    r_data = 32'd0;
    if (!rst) begin
      ready  = 1'b1;
      r_data = 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (mem_w_en) begin
            ready = 1'b0;
          end else if (mem_r_en) begin
            ready  = cache_hit;
            r_data = cache_hit ? cache_out_data : 32'd0;
          end else begin
            ready = 1'b1;
          end
        end
        ST_READ_MISS, ST_WR_PEEK, ST_WR_SRAM: ready = 1'b0;
        ST_FILL: begin
          ready  = 1'b1;
          r_data = address[2] ? line_r[63:32] : line_r[31:0];
        end
        ST_WR_UPD: ready = 1'b1;
        default:   ready = 1'b1;
      endcase
    end
  end

  // SRAM side: aligned line fetch on read miss, word write-through on stores.
  always_comb begin
    sram_r_en    = 1'b0;
    sram_w_en    = 1'b0;
    sram_address = 32'd0;
    sram_w_data  = 32'd0;
    if (!rst) begin
      sram_r_en = 1'b0;
      sram_w_en = 1'b0;
    end else begin
      case (state_r)
        ST_READ_MISS: begin
          sram_r_en    = 1'b1;
          sram_address = {address[31:3], 3'b000};
        end
        ST_WR_SRAM: begin
          sram_w_en    = 1'b1;
          sram_address = address;
          sram_w_data  = w_data;
        end
        default: begin
          sram_r_en = 1'b0;
          sram_w_en = 1'b0;
        end
      endcase
    end
  end

  assign cache_en_write    = cache_en_write_r & rst;
  assign cache_update_data = cache_update_data_r & rst;
  assign cache_in_data1    = line_r[31:0];
  assign cache_in_data2    = line_r[63:32];

endmodule
